card_dealer: RTL and testbench

- Deck controller and dealing arbiter for the blackjack game.
- Owns a 52-card deck as a used-card bitmap and draws pseudo-random, never-repeating cards.
- Serves card requests from two requesters, the dealer-hand path and the player-hand path, one card at a time.
- Sits between the game state machine's deal states and the hand/sum logic; also performs reshuffle on command.

---
 rtl/card_dealer.sv | 128 ++++++++++++
 tb/tb_card_dealer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/card_dealer.sv
// 52-card deck controller: never-repeating draws from a used-card bitmap, two-way request arbitration.
// Optional build macro DETERMINISTIC_DECK_EN: every draw starts at index 0 (lowest unused card).
module card_dealer #(
    parameter int          DECK_SIZE = 52,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       dealerReq,
    input  logic       playerReq,
    input  logic       shuffleReq,
    output logic       cardValid,
    output logic       cardToDealer,
    output logic [3:0] cardRank,
    output logic [1:0] cardSuit,
    output logic [5:0] cardsLeft,
    output logic       deckEmpty,
    output logic       busy
);

    localparam logic [5:0] FULL_DECK = 6'(DECK_SIZE);
    localparam logic [5:0] LAST_IDX  = 6'(DECK_SIZE - 1);

    typedef enum logic [1:0] {S_IDLE, S_SHUFFLE, S_SEARCH, S_DELIVER} state_t;

    state_t                state, state_next;
    logic [DECK_SIZE-1:0]  used;
    logic [5:0]            idx, start_idx, left;
    logic [15:0]           lfsr;
    logic                  last_grant, grant_dealer, grant_dealer_next;
    logic                  take, hit;
    logic [3:0]            rank_q, idx_rank;
    logic [1:0]            suit_q, idx_suit;

`ifdef DETERMINISTIC_DECK_EN
    assign start_idx = '0;
`else
    // Fold 52..63 back onto 40..51 so every LFSR value maps to a card.
    assign start_idx = (lfsr[5:0] < FULL_DECK) ? lfsr[5:0] : lfsr[5:0] - 6'd12;
`endif

    always_comb begin
        idx_suit = 2'd0;
        idx_rank = 4'(idx + 6'd1);
        if (idx >= 6'd39) begin
            idx_suit = 2'd3;
            idx_rank = 4'(idx - 6'd38);
        end else if (idx >= 6'd26) begin
            idx_suit = 2'd2;
            idx_rank = 4'(idx - 6'd25);
        end else if (idx >= 6'd13) begin
            idx_suit = 2'd1;
            idx_rank = 4'(idx - 6'd12);
        end
    end

    always_comb begin
        state_next        = state;
        grant_dealer_next = grant_dealer;
        take              = 1'b0;
        hit               = 1'b0;
        case (state)
            S_IDLE: begin
                if (shuffleReq) begin
                    state_next = S_SHUFFLE;
                end else if ((dealerReq || playerReq) && !deckEmpty) begin
                    take       = 1'b1;
                    state_next = S_SEARCH;
                    if (dealerReq && playerReq) grant_dealer_next = ~last_grant;
                    else                        grant_dealer_next = dealerReq;
                end
            end
            S_SHUFFLE: state_next = S_IDLE;
            S_SEARCH: begin
                hit = ~used[idx];
                if (hit) state_next = S_DELIVER;
            end
            S_DELIVER: state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            used         <= '0;
            left         <= FULL_DECK;
            lfsr         <= LFSR_SEED;
            last_grant   <= 1'b0;
            grant_dealer <= 1'b0;
            idx          <= '0;
            rank_q       <= '0;
            suit_q       <= '0;
        end else begin
            state        <= state_next;
            lfsr         <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
            grant_dealer <= grant_dealer_next;
            if (take) begin
                last_grant <= grant_dealer_next;
                idx        <= start_idx;
            end
            if (state == S_SHUFFLE) begin
                used <= '0;
                left <= FULL_DECK;
            end
            if (state == S_SEARCH) begin
                if (hit) begin
                    used[idx] <= 1'b1;
                    left      <= left - 6'd1;
                    rank_q    <= idx_rank;
                    suit_q    <= idx_suit;
                end else begin
                    idx <= (idx == LAST_IDX) ? '0 : idx + 6'd1;
                end
            end
        end
    end

    // Gated by reset so a reset landing in the delivery cycle suppresses the pulse.
    assign cardValid    = (state == S_DELIVER) && !reset;
    assign cardToDealer = grant_dealer;
    assign cardRank     = rank_q;
    assign cardSuit     = suit_q;
    assign cardsLeft    = left;
    assign deckEmpty    = (left == '0);
    assign busy         = (state != S_IDLE);

endmodule

// File: tb/tb_card_dealer.sv
// Scoreboard bench for card_dealer: a deck model predicts each delivered card and its delivery cycle.
module tb_card_dealer;

    localparam logic [15:0] SEED = 16'hACE1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       dealerReq = 1'b0, playerReq = 1'b0, shuffleReq = 1'b0;
    logic       cardValid, cardToDealer, deckEmpty, busy;
    logic [3:0] cardRank;
    logic [1:0] cardSuit;
    logic [5:0] cardsLeft;

    card_dealer #(.DECK_SIZE(52), .LFSR_SEED(SEED)) dut (
        .clk(clk), .reset(reset), .dealerReq(dealerReq), .playerReq(playerReq),
        .shuffleReq(shuffleReq), .cardValid(cardValid), .cardToDealer(cardToDealer),
        .cardRank(cardRank), .cardSuit(cardSuit), .cardsLeft(cardsLeft),
        .deckEmpty(deckEmpty), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic dealer;
        int   rank;
        int   suit;
        int   left;
        int   due;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    int          total = 0, passed = 0;
    int          cyc = 0;
    logic [15:0] m_lfsr;
    bit   [51:0] m_used = '0;
    int          m_left = 52;
    logic        m_last = 1'b0;
    bit          uniq_on = 1'b0;
    bit          seen [52];

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) m_lfsr <= reset ? SEED : ({1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0));

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d required %0d", name, act, req);
    endtask

    function automatic int start_of(input logic [15:0] v);
        int s;
        s = int'(v[5:0]);
`ifdef DETERMINISTIC_DECK_EN
        return 0;
`else
        return (s < 52) ? s : s - 12;
`endif
    endfunction

    function automatic void find(input int st, output int j, output int pr);
        j = -1;
        pr = 0;
        for (int unsigned n = 0; n < 52; n++) begin
            if (!m_used[(st + int'(n)) % 52]) begin
                j  = (st + int'(n)) % 52;
                pr = int'(n) + 1;
                return;
            end
        end
    endfunction

    always @(negedge clk) begin
        if (cardValid) begin
            if (q.size() == 0) begin
                total++;
                $display("FAIL unexpected_cardValid: got 1 required 0 (rank %0d suit %0d)", cardRank, cardSuit);
            end else begin
                e = q.pop_front();
                check("cardToDealer", cardToDealer, e.dealer);
                check("cardRank", cardRank, e.rank);
                check("cardSuit", cardSuit, e.suit);
                check("cardsLeft", cardsLeft, e.left);
                check("deckEmpty", deckEmpty, (e.left == 0) ? 1 : 0);
                check("deliver_cycle", cyc, e.due);
            end
            if (uniq_on && cardRank >= 1 && cardRank <= 13) begin
                check("card_unique", seen[int'(cardSuit) * 13 + int'(cardRank) - 1], 0);
                seen[int'(cardSuit) * 13 + int'(cardRank) - 1] = 1'b1;
            end
        end
    end

    task automatic wait_drain();
        for (int i = 0; i < 60; i++) begin
            if (q.size() == 0) break;
            @(posedge clk); #1;
        end
        if (q.size() != 0) begin
            check("deliver_timeout", q.size(), 0);
            q.delete();
        end
    endtask

    // Called in an idle cycle; requests are sampled at the next edge.
    task automatic deal(input logic d, input logic p, input bit hold);
        int   j, pr;
        logic who;
        dealerReq = d;
        playerReq = p;
        who = (d && p) ? ~m_last : d;
        m_last = who;
        find(start_of(m_lfsr), j, pr);
        m_used[j] = 1'b1;
        m_left--;
        q.push_back('{who, j % 13 + 1, j / 13, m_left, cyc + 1 + pr});
        @(posedge clk); #1;
        if (!hold) begin
            dealerReq = 1'b0;
            playerReq = 1'b0;
        end
        wait_drain();
        check("rank_hold", cardRank, j % 13 + 1);
        check("suit_hold", cardSuit, j / 13);
    endtask

    task automatic model_reset();
        m_used = '0;
        m_left = 52;
        m_last = 1'b0;
    endtask

    // Start a player draw, then reset either in the first search cycle or in the delivery cycle.
    task automatic abort(input bit in_deliver);
        int j, pr;
        playerReq = 1'b1;
        find(start_of(m_lfsr), j, pr);
        @(posedge clk); #1;
        playerReq = 1'b0;
        check("busy_in_search", busy, 1);
        if (in_deliver) begin
            repeat (pr) begin @(posedge clk); #1; end
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        repeat (3) begin @(posedge clk); #1; end
        check("abort_cardsLeft", cardsLeft, 52);
        check("abort_busy", busy, 0);
        check("abort_deckEmpty", deckEmpty, 0);
    endtask

    initial begin
        bit busy_seen;
        int distinct;

        repeat (3) @(posedge clk);
        #1;
        check("rst_cardsLeft", cardsLeft, 52);
        check("rst_deckEmpty", deckEmpty, 0);
        check("rst_cardValid", cardValid, 0);
        check("rst_cardToDealer", cardToDealer, 0);
        check("rst_cardRank", cardRank, 0);
        check("rst_cardSuit", cardSuit, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        deal(1'b1, 1'b0, 1'b0);
        check("busy_after_first", busy, 0);
        check("cardsLeft_after_first", cardsLeft, 51);

        for (int i = 0; i < 4; i++) deal(1'b1, 1'b1, (i != 3));

        while (m_left > 0) deal(1'b0, 1'b1, 1'b0);
        check("empty_cardsLeft", cardsLeft, 0);
        check("empty_deckEmpty", deckEmpty, 1);

        busy_seen = 1'b0;
        playerReq = 1'b1;
        repeat (60) begin
            @(posedge clk); #1;
            busy_seen |= busy;
        end
        check("empty_req_busy", busy_seen, 0);

        shuffleReq = 1'b1;
        @(posedge clk); #1;
        check("shuffle_busy", busy, 1);
        shuffleReq = 1'b0;
        @(posedge clk); #1;
        check("shuffle_cardsLeft", cardsLeft, 52);
        check("shuffle_deckEmpty", deckEmpty, 0);
        check("shuffle_idle", busy, 0);
        model_reset();
        m_last = 1'b0;
        deal(1'b0, 1'b1, 1'b0);

        abort(1'b0);
        abort(1'b1);

        for (int k = 0; k < 52; k++) seen[k] = 1'b0;
        uniq_on = 1'b1;
        for (int i = 0; i < 52; i++) begin
            if (i == 0)          deal(1'b1, 1'b1, 1'b0);
            else if (i % 2 == 1) deal(1'b0, 1'b1, 1'b0);
            else                 deal(1'b1, 1'b0, 1'b0);
        end
        uniq_on = 1'b0;
        distinct = 0;
        for (int k = 0; k < 52; k++) distinct += int'(seen[k]);
        check("distinct_cards", distinct, 52);
        check("final_deckEmpty", deckEmpty, 1);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
